vfifo_mq_ctrl: RTL and testbench

// Multi-queue FIFO controller that splits one single-clock dual-port RAM (port A write, port B read) into
// NQ equal, statically partitioned circular queues.

---
 rtl/vfifo_mq_ctrl_pkg.sv | 18 +
 rtl/vfifo_q_ptr.sv | 41 ++++
 rtl/vfifo_mq_ctrl.sv | 74 +++++++
 tb/tb_vfifo_mq_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vfifo_mq_ctrl_pkg.sv
// Shared definitions for the multi-queue FIFO controller.
// Provides the log2 helper used to derive the queue-id and index widths.
package vfifo_mq_ctrl_pkg;

    // Ceiling log2, usable in constant expressions. Returns 0 for n <= 1.
    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vfifo_q_ptr.sv
// One queue's read/write pointer pair with wrap bit and derived full/empty flags.
// The index outputs form the low bits of the RAM address inside the queue's partition.
module vfifo_q_ptr #(
    parameter int PW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_wr,
    input  logic          inc_rd,
    input  logic          clr,
    output logic [PW-1:0] wr_idx,
    output logic [PW-1:0] rd_idx,
    output logic          full,
    output logic          empty
);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (inc_wr) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (inc_rd) rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    always_comb begin
        empty  = (wr_ptr == rd_ptr);
        full   = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
        wr_idx = wr_ptr[PW-1:0];
        rd_idx = rd_ptr[PW-1:0];
    end

endmodule

// File: rtl/vfifo_mq_ctrl.sv
// Multi-queue FIFO controller: partitions one dual-port RAM into NQ circular queues
// and arbitrates one push and one pop per cycle against per-queue pointers.
module vfifo_mq_ctrl
    import vfifo_mq_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int ADDR_WIDTH = 8,
    parameter  int NQ         = 4,
    localparam int QW         = clog2_f(NQ),
    localparam int PW         = ADDR_WIDTH - QW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [QW-1:0]         push_q,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ack,
    input  logic                  pop,
    input  logic [QW-1:0]         pop_q,
    output logic                  pop_ack,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic [NQ-1:0]         flush,
    output logic [NQ-1:0]         full,
    output logic [NQ-1:0]         empty,
    output logic [DATA_WIDTH-1:0] ram_d_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_adr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    logic [NQ-1:0] inc_wr;
    logic [NQ-1:0] inc_rd;
    logic [PW-1:0] wr_idx [NQ];
    logic [PW-1:0] rd_idx [NQ];

    for (genvar i = 0; i < NQ; i++) begin : g_q
        assign inc_wr[i] = push_ack && (push_q == QW'(i));
        assign inc_rd[i] = pop_ack && (pop_q == QW'(i));

        vfifo_q_ptr #(
            .PW (PW)
        ) u_ptr (
            .clk    (clk),
            .rst    (rst),
            .inc_wr (inc_wr[i]),
            .inc_rd (inc_rd[i]),
            .clr    (flush[i]),
            .wr_idx (wr_idx[i]),
            .rd_idx (rd_idx[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end

    // Acks look only at pre-edge flags, so a same-cycle push never rescues a pop
    // from an empty queue and the RAM never reads and writes one address together.
    always_comb begin
        push_ack  = push && !full[push_q] && !flush[push_q];
        pop_ack   = pop && !empty[pop_q] && !flush[pop_q];
        ram_we_a  = push_ack;
        ram_d_a   = push_data;
        ram_adr_a = {push_q, wr_idx[push_q]};
        ram_adr_b = {pop_q, rd_idx[pop_q]};
        pop_data  = ram_q_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pop_valid <= 1'b0;
        else     pop_valid <= pop_ack;
    end

endmodule

// File: tb/tb_vfifo_mq_ctrl.sv
// Self-checking bench for vfifo_mq_ctrl (4 queues x 4 entries): directed vector table,
// randomized traffic against a queue-based reference model, and an async reset mid-stream.
module tb_vfifo_mq_ctrl;

    logic       clk;
    logic       rst;
    logic       push;
    logic [1:0] push_q;
    logic [7:0] push_data;
    logic       push_ack;
    logic       pop;
    logic [1:0] pop_q;
    logic       pop_ack;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [3:0] flush;
    logic [3:0] full;
    logic [3:0] empty;
    logic [7:0] ram_d_a;
    logic [3:0] ram_adr_a;
    logic       ram_we_a;
    logic [3:0] ram_adr_b;
    logic [7:0] ram_q_b;

    int tests = 0;
    int fails = 0;

    vfifo_mq_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .NQ         (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_q    (push_q),
        .push_data (push_data),
        .push_ack  (push_ack),
        .pop       (pop),
        .pop_q     (pop_q),
        .pop_ack   (pop_ack),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .flush     (flush),
        .full      (full),
        .empty     (empty),
        .ram_d_a   (ram_d_a),
        .ram_adr_a (ram_adr_a),
        .ram_we_a  (ram_we_a),
        .ram_adr_b (ram_adr_b),
        .ram_q_b   (ram_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with registered read address.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_adr_a] <= ram_d_a;
        ram_q_b <= mem[ram_adr_b];
    end

    // Reference model: one plain FIFO per queue, capacity 4.
    logic [7:0] mq [4][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic pu, input logic [1:0] pq, input logic [7:0] pd,
                         input logic po, input logic [1:0] oq, input logic [3:0] fl);
        push = pu; push_q = pq; push_data = pd;
        pop = po; pop_q = oq; flush = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
        for (int q = 0; q < 4; q++) mq[q].delete();
    endtask

    typedef struct {
        logic       pu;
        logic [1:0] pq;
        logic [7:0] pd;
        logic       po;
        logic [1:0] oq;
        logic [3:0] fl;
        logic       epa;
        logic       eoa;
        logic [3:0] ee;
        logic [3:0] ef;
        logic       epv;
        logic [7:0] epd;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t v(logic pu, logic [1:0] pq, logic [7:0] pd, logic po, logic [1:0] oq,
                               logic [3:0] fl, logic epa, logic eoa, logic [3:0] ee, logic [3:0] ef,
                               logic epv, logic [7:0] epd);
        vec_t r;
        r.pu = pu; r.pq = pq; r.pd = pd; r.po = po; r.oq = oq; r.fl = fl;
        r.epa = epa; r.eoa = eoa; r.ee = ee; r.ef = ef; r.epv = epv; r.epd = epd;
        return r;
    endfunction

    // One model-checked cycle: flags and acks before the edge, pop result after it.
    task automatic rstep(input logic pu, input logic [1:0] pq, input logic [7:0] pd,
                         input logic po, input logic [1:0] oq, input logic [3:0] fl);
        logic [3:0] ee, ef;
        logic       epa, eoa, epv;
        logic [7:0] epd;
        @(negedge clk);
        drive(pu, pq, pd, po, oq, fl);
        #1;
        for (int q = 0; q < 4; q++) begin
            ee[q] = (mq[q].size() == 0);
            ef[q] = (mq[q].size() == 4);
        end
        epa = pu && (mq[pq].size() < 4) && !fl[pq];
        eoa = po && (mq[oq].size() > 0) && !fl[oq];
        chk("rnd_empty", 32'(empty), 32'(ee));
        chk("rnd_full", 32'(full), 32'(ef));
        chk("rnd_push_ack", 32'(push_ack), 32'(epa));
        chk("rnd_pop_ack", 32'(pop_ack), 32'(eoa));
        chk("rnd_we_a", 32'(ram_we_a), 32'(epa));
        if (epa) chk("rnd_d_a", 32'(ram_d_a), 32'(pd));
        epv = eoa;
        epd = 8'h00;
        if (eoa) epd = mq[oq].pop_front();
        if (epa) mq[pq].push_back(pd);
        for (int q = 0; q < 4; q++) if (fl[q]) mq[q].delete();
        @(posedge clk);
        #1;
        chk("rnd_pop_valid", 32'(pop_valid), 32'(epv));
        if (epv) chk("rnd_pop_data", 32'(pop_data), 32'(epd));
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        //      pu pq pd     po oq fl        epa eoa ee       ef       epv epd
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 2, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h11, 0, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h22, 0, 0, 4'b0000, 1, 0, 4'b1101, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h33, 0, 0, 4'b0000, 1, 0, 4'b1101, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h44, 0, 0, 4'b0000, 1, 0, 4'b1101, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 1, 8'h55, 0, 0, 4'b0000, 0, 0, 4'b1101, 4'b0010, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'b0000, 0, 1, 4'b1101, 4'b0010, 1, 8'h11));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'b0000, 0, 1, 4'b1101, 4'b0000, 1, 8'h22));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'b0000, 0, 1, 4'b1101, 4'b0000, 1, 8'h33));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'b0000, 0, 1, 4'b1101, 4'b0000, 1, 8'h44));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        // q3 fill, partial drain, refill across the index wrap, full drain
        tbl.push_back(v(1, 3, 8'ha1, 0, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 3, 8'ha2, 0, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 3, 8'ha3, 0, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 3, 8'ha4, 0, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b1000, 1, 8'ha1));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b0000, 1, 8'ha2));
        tbl.push_back(v(1, 3, 8'ha5, 0, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 3, 8'ha6, 0, 0, 4'b0000, 1, 0, 4'b0111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b1000, 1, 8'ha3));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b0000, 1, 8'ha4));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b0000, 1, 8'ha5));
        tbl.push_back(v(0, 0, 8'h00, 1, 3, 4'b0000, 0, 1, 4'b0111, 4'b0000, 1, 8'ha6));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        // q0 simultaneous push/pop at occupancy 1, then at full
        tbl.push_back(v(1, 0, 8'hb1, 0, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 0, 8'hb2, 1, 0, 4'b0000, 1, 1, 4'b1110, 4'b0000, 1, 8'hb1));
        tbl.push_back(v(1, 0, 8'hb3, 0, 0, 4'b0000, 1, 0, 4'b1110, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 0, 8'hb4, 0, 0, 4'b0000, 1, 0, 4'b1110, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 0, 8'hb5, 0, 0, 4'b0000, 1, 0, 4'b1110, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 0, 8'hb6, 1, 0, 4'b0000, 0, 1, 4'b1110, 4'b0001, 1, 8'hb2));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'b0000, 0, 1, 4'b1110, 4'b0000, 1, 8'hb3));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'b0000, 0, 1, 4'b1110, 4'b0000, 1, 8'hb4));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'b0000, 0, 1, 4'b1110, 4'b0000, 1, 8'hb5));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        // empty q0: push acked, pop refused; data follows next cycle
        tbl.push_back(v(1, 0, 8'hc1, 1, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 0, 4'b0000, 0, 1, 4'b1110, 4'b0000, 1, 8'hc1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));
        // q2 flush right after a pop; q1 unaffected
        tbl.push_back(v(1, 2, 8'hd1, 0, 0, 4'b0000, 1, 0, 4'b1111, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 2, 8'hd2, 0, 0, 4'b0000, 1, 0, 4'b1011, 4'b0000, 0, 8'h00));
        tbl.push_back(v(1, 2, 8'hd3, 0, 0, 4'b0000, 1, 0, 4'b1011, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 2, 4'b0000, 0, 1, 4'b1011, 4'b0000, 1, 8'hd1));
        tbl.push_back(v(1, 1, 8'he1, 1, 2, 4'b0100, 1, 0, 4'b1011, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1101, 4'b0000, 0, 8'h00));
        tbl.push_back(v(0, 0, 8'h00, 1, 1, 4'b0000, 0, 1, 4'b1101, 4'b0000, 1, 8'he1));
        tbl.push_back(v(0, 0, 8'h00, 0, 0, 4'b0000, 0, 0, 4'b1111, 4'b0000, 0, 8'h00));

        do_reset();
        #1;
        chk("reset_empty", 32'(empty), 32'hf);
        chk("reset_full", 32'(full), 32'h0);
        chk("reset_pop_valid", 32'(pop_valid), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].pu, tbl[i].pq, tbl[i].pd, tbl[i].po, tbl[i].oq, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].ee));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tbl[i].ef));
            chk($sformatf("vec%0d_push_ack", i), 32'(push_ack), 32'(tbl[i].epa));
            chk($sformatf("vec%0d_pop_ack", i), 32'(pop_ack), 32'(tbl[i].eoa));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(tbl[i].epv));
            if (tbl[i].epv) chk($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(tbl[i].epd));
        end

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] fl;
            fl = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'b0000;
            rstep(1'($urandom_range(0, 2) != 0), 2'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 2'($urandom), fl);
        end

        // Async reset while q1 is full and a pop result is being delivered.
        do_reset();
        for (int k = 0; k < 4; k++) rstep(1, 1, 8'(8'h70 + k), 0, 0, 4'b0000);
        rstep(1, 0, 8'h5a, 0, 0, 4'b0000);
        rstep(0, 0, 8'h00, 1, 0, 4'b0000);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_empty", 32'(empty), 32'hf);
        chk("async_rst_full", 32'(full), 32'h0);
        chk("async_rst_pop_valid", 32'(pop_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int q = 0; q < 4; q++) mq[q].delete();
        rstep(0, 0, 8'h00, 1, 1, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
